// File: rtl/apb_reg_slave_if.sv
// APB completer-side bus bundle for apb_reg_slave.
// The master modport is the requester's view; the slave modport is the register block's view.
interface apb_reg_slave_if;
    logic        psel_i;
    logic        penable_i;
    logic [31:0] paddr_i;
    logic        pwrite_i;
    logic [31:0] pwdata_i;
    logic [31:0] prdata_o;
    logic        pready_o;
    logic        pslverr_o;

    modport master (
        output psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
        input  prdata_o, pready_o, pslverr_o
    );

    modport slave (
        input  psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
        output prdata_o, pready_o, pslverr_o
    );
endinterface

// File: rtl/apb_reg_slave.sv
// APB register completer: NUM_REGS read/write words plus a read-only STATUS word,
// programmable wait states, pslverr on illegal accesses, register 0 exported.
module apb_reg_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_A000,
    parameter int          NUM_REGS    = 4,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic              pclk,
    input  logic              preset,
    apb_reg_slave_if.slave    apb,
    output logic [31:0]       reg0_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READY
    } state_t;

    // ST_WAIT lasts WAIT_CYCLES cycles, so the counter starts one below the wait count.
    localparam logic [3:0]  WAIT_LOAD   = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [31:0] STATUS_OFFS = 32'h0000_0040;
    localparam logic [31:0] RW_SPAN     = 32'(4 * NUM_REGS);

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        pready_q, pready_d;
    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic [15:0] rd_cnt_q, rd_cnt_d;

    logic [31:0] offset;
    logic [3:0]  reg_idx;
    logic        misaligned;
    logic        rw_hit;
    logic        status_hit;
    logic        access_err;
    logic        access_req;
    logic        in_ready;
    logic [31:0] rd_value;

    always_comb begin
        offset     = apb.paddr_i - BASE_ADDR;
        reg_idx    = offset[5:2];
        misaligned = (apb.paddr_i[1:0] != 2'b00);
        rw_hit     = (offset < RW_SPAN);
        status_hit = (offset == STATUS_OFFS);
        access_err = misaligned | ~(rw_hit | status_hit) | (status_hit & apb.pwrite_i);
        access_req = apb.psel_i & apb.penable_i;
        in_ready   = (state_q == ST_READY);
    end

    always_comb begin
        rd_value = 32'h0;
        if (status_hit) begin
            rd_value = {rd_cnt_q, wr_cnt_q};
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (reg_idx == 4'(i)) begin
                    rd_value = regs_q[i];
                end
            end
        end
    end

    // Read data and error are only presented during the completing cycle.
    assign apb.prdata_o  = (in_ready && !access_err && !apb.pwrite_i) ? rd_value : 32'h0;
    assign apb.pslverr_o = in_ready && access_err;
    assign apb.pready_o  = pready_q;
    assign reg0_o        = regs_q[0];

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        pready_d   = 1'b0;
        regs_d     = regs_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (access_req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d  = ST_READY;
                        pready_d = 1'b1;
                    end else begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (!access_req) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = 4'd0;
                end else if (wait_cnt_q == 4'd0) begin
                    state_d  = ST_READY;
                    pready_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_READY: begin
                state_d = ST_IDLE;
                if (!access_err) begin
                    if (apb.pwrite_i) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (reg_idx == 4'(i)) begin
                                regs_d[i] = apb.pwdata_i;
                            end
                        end
                        if (wr_cnt_q != 16'hFFFF) begin
                            wr_cnt_d = wr_cnt_q + 16'd1;
                        end
                    end else if (rd_cnt_q != 16'hFFFF) begin
                        rd_cnt_d = rd_cnt_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            pready_q   <= 1'b0;
            wr_cnt_q   <= 16'h0;
            rd_cnt_q   <= 16'h0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            pready_q   <= pready_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed plus randomized bench for apb_reg_slave: three builds (WAIT_CYCLES 0, 1, 3),
// with a word-level register/counter model checking the WAIT_CYCLES=1 build.
module tb_apb_reg_slave;

    localparam logic [31:0] BASE = 32'h0000_A000;
    localparam int          NREG = 4;

    logic pclk;
    logic preset;

    logic        psel_r    [3];
    logic        penable_r [3];
    logic [31:0] paddr_r   [3];
    logic        pwrite_r  [3];
    logic [31:0] pwdata_r  [3];
    wire  [31:0] prdata_w  [3];
    wire         pready_w  [3];
    wire         pslverr_w [3];
    wire  [31:0] reg0_w    [3];

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] mregs [NREG];
    int          mwr;
    int          mrd;

    apb_reg_slave_if bus [3] ();

    // Index 0 -> WAIT_CYCLES 0, index 1 -> 1, index 2 -> 3.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign bus[g].psel_i    = psel_r[g];
        assign bus[g].penable_i = penable_r[g];
        assign bus[g].paddr_i   = paddr_r[g];
        assign bus[g].pwrite_i  = pwrite_r[g];
        assign bus[g].pwdata_i  = pwdata_r[g];
        assign prdata_w[g]      = bus[g].prdata_o;
        assign pready_w[g]      = bus[g].pready_o;
        assign pslverr_w[g]     = bus[g].pslverr_o;

        apb_reg_slave #(
            .BASE_ADDR  (BASE),
            .NUM_REGS   (NREG),
            .WAIT_CYCLES((g == 2) ? 3 : g)
        ) u_dut (
            .pclk  (pclk),
            .preset(preset),
            .apb   (bus[g]),
            .reg0_o(reg0_w[g])
        );
    end

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NREG; i++) mregs[i] = 32'h0;
        mwr = 0;
        mrd = 0;
    endtask

    // Expected response of one completed access, derived from the address map rules.
    task automatic modelAccess(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                               output logic exp_err, output logic [31:0] exp_rdata);
        logic [31:0] off;
        bit          aligned, is_rw, is_st;
        off       = addr - BASE;
        aligned   = (addr % 4) == 0;
        is_rw     = aligned && (off < 4 * NREG);
        is_st     = aligned && (off == 64);
        exp_err   = !(is_rw || is_st) || (is_st && wr);
        exp_rdata = 32'h0;
        if (!exp_err) begin
            if (wr) begin
                if (is_rw) mregs[off / 4] = wdata;
                mwr = (mwr < 65535) ? mwr + 1 : 65535;
            end else begin
                if (is_rw) exp_rdata = mregs[off / 4];
                else       exp_rdata = (mrd << 16) | mwr;
                mrd = (mrd < 65535) ? mrd + 1 : 65535;
            end
        end
    endtask

    task automatic applyStimulus(input int d, input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                                 output logic [31:0] rdata, output logic err, output int cycles);
        @(negedge pclk);
        psel_r[d]    = 1'b1;
        penable_r[d] = 1'b0;
        paddr_r[d]   = addr;
        pwrite_r[d]  = wr;
        pwdata_r[d]  = wdata;
        @(negedge pclk);
        penable_r[d] = 1'b1;
        cycles = 1;
        while (pready_w[d] !== 1'b1 && cycles < 64) begin
            @(negedge pclk);
            cycles++;
        end
        rdata        = prdata_w[d];
        err          = pslverr_w[d];
        psel_r[d]    = 1'b0;
        penable_r[d] = 1'b0;
    endtask

    task automatic doAccess(input string tag, input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
        logic [31:0] rdata, exp_rdata;
        logic        err, exp_err;
        int          cycles;
        applyStimulus(1, addr, wr, wdata, rdata, err, cycles);
        modelAccess(addr, wr, wdata, exp_err, exp_rdata);
        checkOutput({tag, " cycles"}, 32'(cycles), 32'd3);
        checkOutput({tag, " pslverr"}, {31'h0, err}, {31'h0, exp_err});
        if (!wr || exp_err) checkOutput({tag, " prdata"}, rdata, exp_rdata);
    endtask

    task automatic resetDut();
        @(negedge pclk);
        preset = 1'b1;
        repeat (2) @(negedge pclk);
        preset = 1'b0;
        modelReset();
    endtask

    initial begin
        logic [31:0] rdata, addr, wdata;
        logic        err, wr;
        int          cycles, seen;

        for (int i = 0; i < 3; i++) begin
            psel_r[i] = 1'b0; penable_r[i] = 1'b0; paddr_r[i] = 32'h0;
            pwrite_r[i] = 1'b0; pwdata_r[i] = 32'h0;
        end
        modelReset();
        preset = 1'b1;
        repeat (3) @(negedge pclk);
        checkOutput("reset pready",  {31'h0, pready_w[1]},  32'h0);
        checkOutput("reset prdata",  prdata_w[1],           32'h0);
        checkOutput("reset pslverr", {31'h0, pslverr_w[1]}, 32'h0);
        checkOutput("reset reg0",    reg0_w[1],             32'h0);
        preset = 1'b0;

        doAccess("wr A004", 32'h0000_A004, 1'b1, 32'hDEAD_BEEF);
        doAccess("rd A004", 32'h0000_A004, 1'b0, 32'h0);

        resetDut();
        applyStimulus(1, 32'h0000_A000, 1'b1, 32'h1234_5678, rdata, err, cycles);
        modelAccess(32'h0000_A000, 1'b1, 32'h1234_5678, err, rdata);
        checkOutput("reg0 in ready cycle", reg0_w[1], 32'h0);
        @(negedge pclk);
        checkOutput("reg0 after commit", reg0_w[1], 32'h1234_5678);
        doAccess("rd status one write", 32'h0000_A040, 1'b0, 32'h0);

        doAccess("rd A010 unmapped", 32'h0000_A010, 1'b0, 32'h0);
        doAccess("rd A002 misaligned", 32'h0000_A002, 1'b0, 32'h0);
        doAccess("wr A040 status", 32'h0000_A040, 1'b1, 32'hCAFE_F00D);
        doAccess("rd A000 after errors", 32'h0000_A000, 1'b0, 32'h0);
        doAccess("rd status after errors", 32'h0000_A040, 1'b0, 32'h0);

        applyStimulus(0, 32'h0000_A000, 1'b0, 32'h0, rdata, err, cycles);
        checkOutput("wait0 cycles", 32'(cycles), 32'd2);
        checkOutput("wait0 prdata", rdata, 32'h0);
        applyStimulus(2, 32'h0000_A000, 1'b0, 32'h0, rdata, err, cycles);
        checkOutput("wait3 cycles", 32'(cycles), 32'd5);
        checkOutput("wait3 pslverr", {31'h0, err}, 32'h0);

        // Abort a write by dropping psel while the slave is still waiting.
        @(negedge pclk);
        psel_r[1] = 1'b1; penable_r[1] = 1'b0; paddr_r[1] = 32'h0000_A008;
        pwrite_r[1] = 1'b1; pwdata_r[1] = 32'hFFFF_FFFF;
        @(negedge pclk);
        penable_r[1] = 1'b1;
        @(negedge pclk);
        psel_r[1] = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge pclk);
            if (pready_w[1] === 1'b1) seen++;
        end
        penable_r[1] = 1'b0;
        checkOutput("abort pready count", 32'(seen), 32'd0);
        doAccess("rd A008 after abort", 32'h0000_A008, 1'b0, 32'h0);
        doAccess("rd status after abort", 32'h0000_A040, 1'b0, 32'h0);

        // Reset asserted during the completing cycle discards the write.
        @(negedge pclk);
        psel_r[1] = 1'b1; penable_r[1] = 1'b0; paddr_r[1] = 32'h0000_A000;
        pwrite_r[1] = 1'b1; pwdata_r[1] = 32'h5555_AAAA;
        @(negedge pclk);
        penable_r[1] = 1'b1;
        cycles = 1;
        while (pready_w[1] !== 1'b1 && cycles < 64) begin
            @(negedge pclk);
            cycles++;
        end
        checkOutput("reset-in-ready cycles", 32'(cycles), 32'd3);
        preset = 1'b1;
        @(negedge pclk);
        checkOutput("reset-in-ready reg0", reg0_w[1], 32'h0);
        checkOutput("reset-in-ready pready", {31'h0, pready_w[1]}, 32'h0);
        psel_r[1] = 1'b0; penable_r[1] = 1'b0;
        @(negedge pclk);
        preset = 1'b0;
        modelReset();
        doAccess("rd status after reset", 32'h0000_A040, 1'b0, 32'h0);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 7))
                0, 1, 2: addr = BASE + 32'(4 * $urandom_range(0, NREG - 1));
                3:       addr = BASE + 32'h40;
                4:       addr = BASE + 32'(4 * $urandom_range(0, NREG - 1)) + 32'($urandom_range(1, 3));
                5:       addr = BASE + 32'(4 * $urandom_range(NREG, 15));
                default: addr = $urandom;
            endcase
            wr    = 1'($urandom_range(0, 1));
            wdata = $urandom;
            doAccess($sformatf("rand%0d %h", n, addr), addr, wr, wdata);
            @(negedge pclk);
            checkOutput($sformatf("rand%0d reg0", n), reg0_w[1], mregs[0]);
        end
        doAccess("rd status final", 32'h0000_A040, 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
